ls1u_intc: RTL and testbench

- Memory-mapped interrupt controller. It is the responder side of the LS1u core interrupt interface.
- Collects up to 8 peripheral interrupt requests and drives INT plus a 24-bit IVEC_addr into the core.
- Observes IN_ISP to detect acceptance and end of service.
- Sits on the core data bus (daddr/dread/dwrite/ddata_o) as a slave. Software programs enables, modes and per-source vectors through that bus.

---
 rtl/ls1u_intc_if.sv | 23 ++
 rtl/ls1u_intc.sv | 140 ++++++++++++++
 tb/tb_ls1u_intc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ls1u_intc_if.sv
// Core-side bus and interrupt handshake between the LS1u core and its interrupt controller.
// Pure wiring bundle; the core is the master of the data bus and of IN_ISP.
interface ls1u_intc_if;
    logic [23:0] daddr;
    logic        dread;
    logic        dwrite;
    logic [7:0]  ddata_o;
    logic [7:0]  rdata_o;
    logic        hit_o;
    logic        INT;
    logic [23:0] IVEC_addr;
    logic        IN_ISP;

    modport master (
        output daddr, dread, dwrite, ddata_o, IN_ISP,
        input  rdata_o, hit_o, INT, IVEC_addr
    );

    modport slave (
        input  daddr, dread, dwrite, ddata_o, IN_ISP,
        output rdata_o, hit_o, INT, IVEC_addr
    );
endinterface

// File: rtl/ls1u_intc.sv
// Memory-mapped interrupt controller: up to 8 prioritised sources, per-source 24-bit vectors.
// Latency: reads 0 cycles, INT 1 edge after an irq edge; no backpressure, writes always land.
module ls1u_intc #(
    parameter logic [23:0] BASE_ADDR  = 24'hFFFFE0,
    parameter int          NSRC       = 8,
    parameter logic [23:0] VEC_BASE   = 24'h000100,
    parameter logic [23:0] VEC_STRIDE = 24'h000010
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_i,
    ls1u_intc_if.slave      bus
);

    logic [NSRC-1:0] ie;
    logic [NSRC-1:0] ip;
    logic [NSRC-1:0] imode;
    logic [NSRC-1:0] irq_q;
    logic [2:0]      active_id;
    logic [23:0]     vec [NSRC];

    logic            sel;
    logic [4:0]      off;
    logic            wr;
    logic [NSRC-1:0] pend;
    logic [2:0]      sel_id;
    logic            int_req;
    logic            accept;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] ip_clr;
    logic [NSRC-1:0] swi_set;
    logic [NSRC-1:0] acc_clr;
    logic [NSRC-1:0] ip_nxt;
    logic [7:0]      ie_w;
    logic [7:0]      ip_w;
    logic [7:0]      imode_w;
    logic [23:0]     ivec;

    assign sel = (bus.daddr[23:5] == BASE_ADDR[23:5]);
    assign off = bus.daddr[4:0];
    assign wr  = bus.dwrite & sel;

    // Priority select and outputs depend on registers only.
    assign pend    = ip & ie;
    assign int_req = |pend;
    assign accept  = int_req & ~bus.IN_ISP;

    always_comb begin
        sel_id = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) sel_id = 3'(i);
        end
    end

    always_comb begin
        ivec = vec[0];
        for (int i = 0; i < NSRC; i++) begin
            if (sel_id == 3'(i)) ivec = vec[i];
        end
    end

    assign bus.INT       = int_req;
    assign bus.IVEC_addr = ivec;

    // Level bits mirror the input; edge bits use set-over-clear.
    always_comb begin
        rise    = irq_i & ~irq_q;
        ip_clr  = '0;
        swi_set = '0;
        acc_clr = '0;
        if (wr && off == 5'h01) ip_clr  = bus.ddata_o[NSRC-1:0];
        if (wr && off == 5'h04) swi_set = bus.ddata_o[NSRC-1:0];
        for (int i = 0; i < NSRC; i++) begin
            acc_clr[i] = accept && (sel_id == 3'(i));
        end
        ip_nxt = (imode & irq_i)
               | (~imode & ((ip & ~(ip_clr | acc_clr)) | rise | swi_set));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie        <= '0;
            ip        <= '0;
            imode     <= '0;
            irq_q     <= '0;
            active_id <= 3'd0;
        end else begin
            irq_q <= irq_i;
            ip    <= ip_nxt;
            if (accept)             active_id <= sel_id;
            if (wr && off == 5'h00) ie        <= bus.ddata_o[NSRC-1:0];
            if (wr && off == 5'h02) imode     <= bus.ddata_o[NSRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                vec[i] <= VEC_BASE + 24'(i) * VEC_STRIDE;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (wr && off == 5'(8 + 3 * i + k)) vec[i][8*k +: 8] <= bus.ddata_o;
                end
            end
        end
    end

    always_comb begin
        ie_w    = '0;
        ip_w    = '0;
        imode_w = '0;
        ie_w[NSRC-1:0]    = ie;
        ip_w[NSRC-1:0]    = ip;
        imode_w[NSRC-1:0] = imode;
    end

    assign bus.hit_o = bus.dread & sel;

    // Zero when not selected so several slaves can be OR-ed onto the read bus.
    always_comb begin
        bus.rdata_o = 8'h00;
        if (bus.hit_o) begin
            case (off)
                5'h00:   bus.rdata_o = ie_w;
                5'h01:   bus.rdata_o = ip_w;
                5'h02:   bus.rdata_o = imode_w;
                5'h03:   bus.rdata_o = {bus.IN_ISP, 4'b0000, active_id};
                default: bus.rdata_o = 8'h00;
            endcase
            for (int i = 0; i < NSRC; i++) begin
                for (int k = 0; k < 3; k++) begin
                    if (off == 5'(8 + 3 * i + k)) bus.rdata_o = vec[i][8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ls1u_intc.sv
// Directed bench for ls1u_intc: expected values go through a scoreboard queue.
// Inputs change 1 ns after a rising edge; outputs are sampled before the next edge.
module tb_ls1u_intc;

    localparam logic [23:0] BASE = 24'hFFFFE0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] irq = 8'h00;

    ls1u_intc_if bus ();

    ls1u_intc #(
        .BASE_ADDR (24'hFFFFE0),
        .NSRC      (8),
        .VEC_BASE  (24'h000100),
        .VEC_STRIDE(24'h000010)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .irq_i(irq),
        .bus  (bus.slave)
    );

    always #10 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] off, input logic [7:0] d);
        bus.daddr   = BASE + {19'b0, off};
        bus.ddata_o = d;
        bus.dwrite  = 1'b1;
        step();
        bus.dwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] off, input logic [7:0] exp);
        bus.daddr = BASE + {19'b0, off};
        bus.dread = 1'b1;
        expect_val({tag, "_hit"}, 32'd1);
        expect_val(tag, {24'b0, exp});
        #1;
        compare({31'b0, bus.hit_o});
        compare({24'b0, bus.rdata_o});
        bus.dread = 1'b0;
    endtask

    task automatic chk_int(input string tag, input logic i, input logic [23:0] v);
        expect_val({tag, "_int"}, {31'b0, i});
        expect_val({tag, "_ivec"}, {8'b0, v});
        compare({31'b0, bus.INT});
        compare({8'b0, bus.IVEC_addr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.daddr   = 24'h0;
        bus.dread   = 1'b0;
        bus.dwrite  = 1'b0;
        bus.ddata_o = 8'h00;
        bus.IN_ISP  = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_int("in_reset", 1'b0, 24'h000100);
        rst = 1'b0;
        step();

        // Reset register contents
        rd("rst_ie",    5'h00, 8'h00);
        rd("rst_ip",    5'h01, 8'h00);
        rd("rst_imode", 5'h02, 8'h00);
        rd("rst_stat",  5'h03, 8'h00);
        step();
        rd("rst_swi",   5'h04, 8'h00);
        rd("rst_v3b0",  5'h11, 8'h30);
        rd("rst_v3b1",  5'h12, 8'h01);
        rd("rst_v3b2",  5'h13, 8'h00);
        chk_int("rst_idle", 1'b0, 24'h000100);

        // Single edge source, accepted on the following edge
        wr(5'h00, 8'h01);
        irq = 8'h01;
        step();
        chk_int("src0_req", 1'b1, 24'h000100);
        rd("src0_ip", 5'h01, 8'h01);
        irq = 8'h00;
        step();
        chk_int("src0_acc", 1'b0, 24'h000100);
        rd("src0_ip_clr", 5'h01, 8'h00);
        bus.IN_ISP = 1'b1;
        rd("src0_stat", 5'h03, 8'h80);
        bus.IN_ISP = 1'b0;

        // Two simultaneous sources: lower index wins, other waits for end of service
        wr(5'h00, 8'h0C);
        irq = 8'h0C;
        step();
        chk_int("pri_first", 1'b1, 24'h000120);
        step();
        bus.IN_ISP = 1'b1;
        chk_int("pri_in_svc", 1'b1, 24'h000130);
        rd("pri_stat2", 5'h03, 8'h82);
        rd("pri_ip", 5'h01, 8'h08);
        irq = 8'h00;
        step();
        step();
        rd("pri_ip_hold", 5'h01, 8'h08);
        bus.IN_ISP = 1'b0;
        chk_int("pri_second", 1'b1, 24'h000130);
        step();
        bus.IN_ISP = 1'b1;
        rd("pri_stat3", 5'h03, 8'h83);
        chk_int("pri_done", 1'b0, 24'h000100);
        bus.IN_ISP = 1'b0;

        // Level-mode source ignores acceptance and IP writes
        wr(5'h02, 8'h02);
        wr(5'h00, 8'h02);
        irq = 8'h02;
        step();
        chk_int("lvl_req", 1'b1, 24'h000110);
        step();
        bus.IN_ISP = 1'b1;
        rd("lvl_ip_acc", 5'h01, 8'h02);
        rd("lvl_stat", 5'h03, 8'h81);
        wr(5'h01, 8'h02);
        rd("lvl_ip_w1c", 5'h01, 8'h02);
        irq = 8'h00;
        step();
        rd("lvl_ip_drop", 5'h01, 8'h00);
        chk_int("lvl_int_drop", 1'b0, 24'h000100);
        wr(5'h02, 8'h00);
        rd("lvl_imode_clr", 5'h02, 8'h00);

        // Byte-wise vector programming and software interrupt
        wr(5'h0B, 8'h11);
        wr(5'h0C, 8'h22);
        wr(5'h0D, 8'h33);
        rd("vec1_b1", 5'h0C, 8'h22);
        wr(5'h00, 8'h02);
        wr(5'h04, 8'h02);
        chk_int("swi_req", 1'b1, 24'h332211);
        rd("swi_read0", 5'h04, 8'h00);
        rd("swi_ip", 5'h01, 8'h02);
        wr(5'h01, 8'h02);
        rd("w1c_ip", 5'h01, 8'h00);
        chk_int("w1c_int", 1'b0, 24'h000100);
        irq = 8'h02;
        wr(5'h01, 8'h02);
        rd("set_wins", 5'h01, 8'h02);
        wr(5'h01, 8'h02);
        rd("w1c_no_edge", 5'h01, 8'h00);
        irq = 8'h00;
        step();

        // Asynchronous reset in the middle of service
        wr(5'h00, 8'hFF);
        wr(5'h04, 8'hFF);
        rd("all_ip", 5'h01, 8'hFF);
        chk_int("all_req", 1'b1, 24'h000100);
        #3 rst = 1'b1;
        #1;
        chk_int("async_rst", 1'b0, 24'h000100);
        step();
        rst = 1'b0;
        bus.IN_ISP = 1'b0;
        step();
        rd("post_ie",    5'h00, 8'h00);
        rd("post_ip",    5'h01, 8'h00);
        rd("post_imode", 5'h02, 8'h00);
        rd("post_stat",  5'h03, 8'h00);
        step();
        rd("post_v1b0",  5'h0B, 8'h10);
        rd("post_v1b2",  5'h0D, 8'h00);
        rd("unmapped",   5'h05, 8'h00);

        // Read outside the window
        bus.daddr = 24'h000010;
        bus.dread = 1'b1;
        expect_val("out_hit", 32'd0);
        expect_val("out_rdata", 32'd0);
        #1;
        compare({31'b0, bus.hit_o});
        compare({24'b0, bus.rdata_o});
        bus.dread = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
